gb_video_mem: RTL and testbench

Video memory responder on the far side of the PPU's VRAM/OAM read interface. Holds 8 KiB VRAM (8000h–9FFFh) and 160-byte OAM (FE00h–FE9Fh), serves the PPU's read requests, arbitrates CPU access according to the current PPU mode, and runs the FF46 OAM DMA copy engine. The PPU keeps the FF46 register for readback; this block only snoops the write to start DMA.

---
 rtl/gb_video_mem.sv | 169 ++++++++++++++++
 tb/tb_gb_video_mem.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_video_mem.sv
// rtl/gb_video_mem.sv - VRAM/OAM responder with PPU read port, CPU arbitration and FF46 OAM DMA
//
// Purpose: holds 8 KiB VRAM (8000h-9FFFh) and 160-byte OAM (FE00h-FE9Fh).
// Port A serves PPU reads; port B serves CPU reads/writes and the OAM DMA engine.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   ADDR, WR, RD             CPU address, write strobe, read strobe
//   MMIO_DATA_out            CPU write data
//   VMEM_DATA_in, VMEM_HIT   registered CPU read data and region-hit flag
//   PPU_MODE, LCD_ON         PPU mode (0 HBL,1 VBL,2 SCAN,3 DRAW) and LCDC[7]
//   PPU_RD, PPU_ADDR         PPU read request and address
//   PPU_DATA_in              registered PPU read data, held between reads
//   DMA_RD, DMA_ADDR         DMA source read strobe and address
//   DMA_DATA                 DMA source byte, valid the cycle after DMA_RD
//   DMA_ACTIVE               DMA transfer in progress
module gb_video_mem #(
  parameter int LCD_GATE = 1,
  parameter int DMA_LEN  = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ADDR,
  input  logic        WR,
  input  logic        RD,
  input  logic [7:0]  MMIO_DATA_out,
  output logic [7:0]  VMEM_DATA_in,
  output logic        VMEM_HIT,
  input  logic [1:0]  PPU_MODE,
  input  logic        LCD_ON,
  input  logic        PPU_RD,
  input  logic [15:0] PPU_ADDR,
  output logic [7:0]  PPU_DATA_in,
  output logic        DMA_RD,
  output logic [15:0] DMA_ADDR,
  input  logic [7:0]  DMA_DATA,
  output logic        DMA_ACTIVE
);

  localparam logic [1:0] MODE_DRAW = 2'd3;
  localparam logic [7:0] DMA_LAST  = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {DMA_IDLE, DMA_REQ, DMA_WRITE} dma_state_e;

  logic [7:0] vram [0:8191];
  logic [7:0] oam  [0:159];

  dma_state_e state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  src_q, src_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic [7:0]  ppu_data_q, ppu_data_d;
  logic [7:0]  vmem_data_q, vmem_data_d;
  logic        vmem_hit_q, vmem_hit_d;

  logic cpu_in_vram, cpu_in_oam, ppu_in_vram, ppu_in_oam;
  logic lcd_gate, vram_blocked, oam_blocked, dma_active;
  logic cpu_vram_we, cpu_oam_we, dma_we, dma_start;
  logic [7:0] dma_src;

  assign cpu_in_vram = (ADDR[15:13] == 3'b100);
  assign cpu_in_oam  = (ADDR[15:8] == 8'hFE) && (ADDR[7:0] < 8'hA0);
  assign ppu_in_vram = (PPU_ADDR[15:13] == 3'b100);
  assign ppu_in_oam  = (PPU_ADDR[15:8] == 8'hFE) && (PPU_ADDR[7:0] < 8'hA0);

  assign dma_active   = (state_q != DMA_IDLE);
  assign dma_we       = (state_q == DMA_WRITE);
  assign lcd_gate     = (LCD_GATE != 0) && LCD_ON;
  assign vram_blocked = lcd_gate && (PPU_MODE == MODE_DRAW);
  // PPU_MODE[1] set means SCAN or DRAW; DMA owns OAM port B outright.
  assign oam_blocked  = (lcd_gate && PPU_MODE[1]) || dma_active;

  assign cpu_vram_we = WR && cpu_in_vram && !vram_blocked;
  assign cpu_oam_we  = WR && cpu_in_oam && !oam_blocked;

  assign dma_start = WR && (ADDR == 16'hFF46);
  // Echo RAM pages E0-FF fold back onto C0-DF.
  assign dma_src   = (MMIO_DATA_out < 8'hE0) ? MMIO_DATA_out : MMIO_DATA_out - 8'h20;

  // Storage: no reset. Reset still suppresses the in-flight DMA write so an
  // abort takes effect on the very edge it is sampled.
  always_ff @(posedge clk) begin
    if (cpu_vram_we) vram[ADDR[12:0]] <= MMIO_DATA_out;
  end

  always_ff @(posedge clk) begin
    if (dma_we && !rst)  oam[idx_q]      <= DMA_DATA;
    else if (cpu_oam_we) oam[ADDR[7:0]]  <= MMIO_DATA_out;
  end

  // Port A: reads see pre-write contents on a same-address collision because
  // the array update and the read register share the same edge.
  always_comb begin
    ppu_data_d = ppu_data_q;
    if (PPU_RD) begin
      if (ppu_in_vram)                   ppu_data_d = vram[PPU_ADDR[12:0]];
      else if (ppu_in_oam && !dma_active) ppu_data_d = oam[PPU_ADDR[7:0]];
      else                               ppu_data_d = 8'hFF;
    end
  end

  // Port B read: a concurrent CPU write shares ADDR and wins arbitration,
  // so the read returns FF but still reports a hit.
  always_comb begin
    vmem_data_d = vmem_data_q;
    vmem_hit_d  = 1'b0;
    if (RD) begin
      vmem_hit_d  = cpu_in_vram || cpu_in_oam;
      vmem_data_d = 8'hFF;
      if (cpu_in_vram && !vram_blocked && !WR)     vmem_data_d = vram[ADDR[12:0]];
      else if (cpu_in_oam && !oam_blocked && !WR)  vmem_data_d = oam[ADDR[7:0]];
    end
  end

  // DMA engine: REQ issues the source read, WRITE stores the returned byte.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    src_d      = src_q;
    dma_addr_d = dma_addr_q;
    if (dma_start) begin
      state_d    = DMA_REQ;
      idx_d      = 8'd0;
      src_d      = dma_src;
      dma_addr_d = {dma_src, 8'h00};
    end else begin
      case (state_q)
        DMA_REQ:   state_d = DMA_WRITE;
        DMA_WRITE: begin
          if (idx_q == DMA_LAST) begin
            state_d = DMA_IDLE;
          end else begin
            state_d    = DMA_REQ;
            idx_d      = idx_q + 8'd1;
            dma_addr_d = {src_q, 8'h00} + {8'h00, idx_q + 8'd1};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DMA_IDLE;
      idx_q       <= 8'd0;
      src_q       <= 8'd0;
      dma_addr_q  <= 16'h0000;
      ppu_data_q  <= 8'h00;
      vmem_data_q <= 8'hFF;
      vmem_hit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      src_q       <= src_d;
      dma_addr_q  <= dma_addr_d;
      ppu_data_q  <= ppu_data_d;
      vmem_data_q <= vmem_data_d;
      vmem_hit_q  <= vmem_hit_d;
    end
  end

  assign PPU_DATA_in  = ppu_data_q;
  assign VMEM_DATA_in = vmem_data_q;
  assign VMEM_HIT     = vmem_hit_q;
  assign DMA_RD       = (state_q == DMA_REQ);
  assign DMA_ADDR     = dma_addr_q;
  assign DMA_ACTIVE   = dma_active;

endmodule

// File: tb/tb_gb_video_mem.sv
// tb/tb_gb_video_mem.sv - self-checking bench for gb_video_mem
module tb_gb_video_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ADDR = 16'h0;
  logic        WR = 1'b0;
  logic        RD = 1'b0;
  logic [7:0]  MMIO_DATA_out = 8'h0;
  logic [7:0]  VMEM_DATA_in;
  logic        VMEM_HIT;
  logic [1:0]  PPU_MODE = 2'd0;
  logic        LCD_ON = 1'b0;
  logic        PPU_RD = 1'b0;
  logic [15:0] PPU_ADDR = 16'h0;
  logic [7:0]  PPU_DATA_in;
  logic        DMA_RD;
  logic [15:0] DMA_ADDR;
  logic [7:0]  DMA_DATA = 8'h0;
  logic        DMA_ACTIVE;

  gb_video_mem #(.LCD_GATE(1), .DMA_LEN(160)) dut (
    .clk(clk), .rst(rst), .ADDR(ADDR), .WR(WR), .RD(RD),
    .MMIO_DATA_out(MMIO_DATA_out), .VMEM_DATA_in(VMEM_DATA_in), .VMEM_HIT(VMEM_HIT),
    .PPU_MODE(PPU_MODE), .LCD_ON(LCD_ON), .PPU_RD(PPU_RD), .PPU_ADDR(PPU_ADDR),
    .PPU_DATA_in(PPU_DATA_in), .DMA_RD(DMA_RD), .DMA_ADDR(DMA_ADDR),
    .DMA_DATA(DMA_DATA), .DMA_ACTIVE(DMA_ACTIVE)
  );

  always #5 clk = ~clk;

  // Reference state: memory images and a system-bus source region C000-C3FF.
  logic [7:0] vram_m [0:8191];
  logic [7:0] oam_m  [0:159];
  logic [7:0] src_mem [0:1023];

  int n_checks = 0;
  int n_pass   = 0;

  // System bus: returns the addressed source byte the cycle after DMA_RD.
  always @(posedge clk) if (DMA_RD) DMA_DATA <= src_mem[DMA_ADDR[9:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_vram(input logic [15:0] a);
    return a >= 16'h8000 && a <= 16'h9FFF;
  endfunction

  function automatic bit is_oam(input logic [15:0] a);
    return a >= 16'hFE00 && a <= 16'hFE9F;
  endfunction

  // CPU may touch VRAM unless drawing with LCD on; OAM unless scanning/drawing with LCD on.
  function automatic bit cpu_allowed(input logic [15:0] a, input int mode, input bit lcd);
    if (is_vram(a)) return !(lcd && mode == 3);
    if (is_oam(a))  return !(lcd && (mode == 2 || mode == 3));
    return 0;
  endfunction

  function automatic logic [7:0] model_byte(input logic [15:0] a);
    if (is_vram(a)) return vram_m[a - 16'h8000];
    if (is_oam(a))  return oam_m[a - 16'hFE00];
    return 8'hFF;
  endfunction

  function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
    if (!cpu_allowed(a, int'(PPU_MODE), LCD_ON)) return;
    if (is_vram(a)) vram_m[a - 16'h8000] = d;
    else if (is_oam(a)) oam_m[a - 16'hFE00] = d;
  endfunction

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    model_write(a, d);
    ADDR = a; MMIO_DATA_out = d; WR = 1'b1;
    step();
    WR = 1'b0;
  endtask

  task automatic cpu_read_check(input string tag, input logic [15:0] a);
    logic [7:0] exp_d;
    logic       exp_h;
    exp_h = is_vram(a) || is_oam(a);
    exp_d = cpu_allowed(a, int'(PPU_MODE), LCD_ON) ? model_byte(a) : 8'hFF;
    ADDR = a; RD = 1'b1;
    step();
    RD = 1'b0;
    check({tag, "_data"}, VMEM_DATA_in, exp_d);
    check({tag, "_hit"}, VMEM_HIT, exp_h);
  endtask

  task automatic ppu_read_check(input string tag, input logic [15:0] a);
    PPU_ADDR = a; PPU_RD = 1'b1;
    step();
    PPU_RD = 1'b0;
    check(tag, PPU_DATA_in, model_byte(a));
  endtask

  task automatic verify_oam(input string tag, input int skip);
    for (int i = 0; i < 160; i++)
      if (i != skip) ppu_read_check(tag, 16'hFE00 + 16'(i));
  endtask

  // Counts DMA_ACTIVE cycles from the current one until it drops, bounded.
  task automatic count_active(output int n);
    n = 0;
    while (DMA_ACTIVE && n < 400) begin
      n++;
      step();
    end
    if (n >= 400) check("dma_timeout", 1, 0);
  endtask

  initial begin
    int n;
    logic [15:0] a;

    for (int i = 0; i < 1024; i++) src_mem[i] = 8'($urandom);
    for (int i = 0; i < 160; i++) begin
      src_mem[16'h100 + i] = 8'(i) ^ 8'hA5;
      src_mem[16'h200 + i] = 8'(i) ^ 8'h5A;
    end

    // Reset state
    repeat (3) step();
    check("rst_ppu_data", PPU_DATA_in, 8'h00);
    check("rst_vmem_data", VMEM_DATA_in, 8'hFF);
    check("rst_vmem_hit", VMEM_HIT, 1'b0);
    check("rst_dma_rd", DMA_RD, 1'b0);
    check("rst_dma_addr", DMA_ADDR, 16'h0000);
    check("rst_dma_active", DMA_ACTIVE, 1'b0);
    rst = 1'b0;
    step();
    check("idle_dma_active", DMA_ACTIVE, 1'b0);

    // Preload everything with the LCD off so no access is blocked
    LCD_ON = 1'b0;
    for (int i = 0; i < 8192; i++) cpu_write(16'h8000 + 16'(i), 8'($urandom));
    for (int i = 0; i < 160; i++) cpu_write(16'hFE00 + 16'(i), 8'($urandom));
    ppu_read_check("ppu_9800", 16'h9800);

    // Directed blocking cases
    LCD_ON = 1'b1; PPU_MODE = 2'd0;
    cpu_write(16'h8000, 8'h3C);
    ppu_read_check("ppu_8000_3c", 16'h8000);
    check("ppu_8000_const", PPU_DATA_in, 8'h3C);
    PPU_MODE = 2'd3;
    cpu_write(16'h8000, 8'h55);
    ppu_read_check("ppu_8000_kept", 16'h8000);
    check("ppu_8000_kept_const", PPU_DATA_in, 8'h3C);
    cpu_read_check("cpu_vram_draw", 16'h8000);
    PPU_MODE = 2'd2;
    cpu_read_check("cpu_oam_scan", 16'hFE00);
    PPU_MODE = 2'd1;
    cpu_write(16'hFE00, 8'h10);
    cpu_read_check("cpu_oam_vblank", 16'hFE00);
    check("cpu_oam_vblank_const", VMEM_DATA_in, 8'h10);
    LCD_ON = 1'b0; PPU_MODE = 2'd3;
    cpu_write(16'h8001, 8'h77);
    cpu_read_check("cpu_vram_lcdoff", 16'h8001);
    cpu_read_check("cpu_hram", 16'hFF80);

    // Randomized CPU / PPU traffic against the reference model (no DMA)
    for (int k = 0; k < 600; k++) begin
      PPU_MODE = 2'($urandom_range(0, 3));
      LCD_ON   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: a = 16'h8000 + 16'($urandom_range(0, 8191));
        1: a = 16'hFE00 + 16'($urandom_range(0, 159));
        default: a = 16'hFF80 + 16'($urandom_range(0, 126));
      endcase
      case ($urandom_range(0, 2))
        0: cpu_write(a, 8'($urandom));
        1: cpu_read_check("rand_cpu", a);
        default: ppu_read_check("rand_ppu", a);
      endcase
    end

    // DMA from C100: cycle-by-cycle source strobes, OAM hidden from the PPU
    PPU_MODE = 2'd0; LCD_ON = 1'b1;
    cpu_write(16'hFF46, 8'hC1);
    for (int c = 1; c <= 320; c++) begin
      check("dma_active", DMA_ACTIVE, 1'b1);
      if (c % 2 == 1) begin
        check("dma_rd_hi", DMA_RD, 1'b1);
        check("dma_addr", DMA_ADDR, 16'hC100 + 16'((c - 1) / 2));
      end else begin
        check("dma_rd_lo", DMA_RD, 1'b0);
      end
      PPU_ADDR = 16'hFE00 + 16'($urandom_range(0, 159)); PPU_RD = 1'b1;
      step();
      PPU_RD = 1'b0;
      check("ppu_oam_dma", PPU_DATA_in, 8'hFF);
    end
    check("dma_done", DMA_ACTIVE, 1'b0);
    for (int i = 0; i < 160; i++) oam_m[i] = 8'(i) ^ 8'hA5;
    verify_oam("oam_c1", -1);

    // Echo-page source: E3 maps to C3
    cpu_write(16'hFF46, 8'hE3);
    check("dma_e3_addr", DMA_ADDR, 16'hC300);
    check("dma_e3_rd", DMA_RD, 1'b1);
    count_active(n);
    check("dma_e3_len", n, 320);
    for (int i = 0; i < 160; i++) oam_m[i] = src_mem[16'h300 + i];
    verify_oam("oam_e3", -1);

    // Restart at cycle 41 with a new source page
    cpu_write(16'hFF46, 8'hC1);
    repeat (40) step();
    ADDR = 16'hFF46; MMIO_DATA_out = 8'hC2; WR = 1'b1;
    step();
    WR = 1'b0;
    check("restart_addr", DMA_ADDR, 16'hC200);
    check("restart_rd", DMA_RD, 1'b1);
    count_active(n);
    check("restart_len", n, 320);
    for (int i = 0; i < 160; i++) oam_m[i] = 8'(i) ^ 8'h5A;
    verify_oam("oam_c2", -1);

    // Reset at cycle 100 aborts; earlier bytes stay, later ones untouched
    cpu_write(16'hFF46, 8'hC1);
    repeat (99) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_active", DMA_ACTIVE, 1'b0);
    check("abort_rd", DMA_RD, 1'b0);
    check("abort_addr", DMA_ADDR, 16'h0000);
    for (int i = 0; i < 49; i++) oam_m[i] = 8'(i) ^ 8'hA5;
    verify_oam("oam_abort", 49);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
